// File: rtl/taxi_key_pkg.sv
// Shared types and default timing for the taxi-meter key path.
// key_filter uses the same CNT_MAX debounce constant.
package taxi_key_pkg;

  localparam int unsigned T_CNT_W = 26;
  localparam int unsigned R_CNT_W = 20;

  // 20 ms debounce at 50 MHz; shared with key_filter
  localparam logic [R_CNT_W-1:0] CNT_MAX      = 20'd999_999;
  localparam logic [R_CNT_W-1:0] REL_MAX_DEF  = CNT_MAX;
  localparam logic [T_CNT_W-1:0] LONG_MAX_DEF = 26'd49_999_999;
  localparam logic [T_CNT_W-1:0] GAP_MAX_DEF  = 26'd14_999_999;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESSED      = 3'd1,
    LONG_HELD    = 3'd2,
    WAIT_GAP     = 3'd3,
    SECOND_PRESS = 3'd4
  } key_state_e;

  // States in which the key is held and a release must be confirmed
  function automatic logic release_phase(input key_state_e s);
    return (s == PRESSED) || (s == LONG_HELD) || (s == SECOND_PRESS);
  endfunction

endpackage

// File: rtl/release_detector.sv
// Release debounce: counts consecutive high key_in cycles and flags a
// confirmed release once the count has reached REL_MAX with the key still high.
module release_detector
  import taxi_key_pkg::*;
#(
  parameter logic [R_CNT_W-1:0] REL_MAX = REL_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clear,
  input  logic enable,
  input  logic key_in,
  output logic confirm_c
);

  logic [R_CNT_W-1:0] r_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
    end else if (clear || !enable || !key_in) begin
      r_cnt <= '0;
    end else if (r_cnt != REL_MAX) begin
      r_cnt <= r_cnt + R_CNT_W'(1);
    end
  end

  assign confirm_c = enable && key_in && (r_cnt == REL_MAX);

endmodule

// File: rtl/key_event_decoder.sv
// Classifies each debounced key gesture as short, long or double press and
// emits one registered single-cycle event per gesture.
module key_event_decoder
  import taxi_key_pkg::*;
#(
  parameter logic [R_CNT_W-1:0] REL_MAX  = REL_MAX_DEF,
  parameter logic [T_CNT_W-1:0] LONG_MAX = LONG_MAX_DEF,
  parameter logic [T_CNT_W-1:0] GAP_MAX  = GAP_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  input  logic key_flag,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic key_busy
);

  key_state_e         state;
  key_state_e         state_nxt;
  logic [T_CNT_W-1:0] t_cnt;
  logic               state_change_c;
  logic               rel_en_c;
  logic               rel_confirm_c;
  logic               short_nxt;
  logic               long_nxt;
  logic               double_nxt;

  assign state_change_c = (state_nxt != state);
  assign rel_en_c       = release_phase(state);

  release_detector #(
    .REL_MAX (REL_MAX)
  ) u_release_detector (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear     (state_change_c),
    .enable    (rel_en_c),
    .key_in    (key_in),
    .confirm_c (rel_confirm_c)
  );

  // State and registered event outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      key_busy     <= 1'b0;
    end else begin
      state        <= state_nxt;
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      double_press <= double_nxt;
      key_busy     <= (state_nxt != IDLE);
    end
  end

  // Hold / gap timer, restarted on every state change
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      t_cnt <= '0;
    end else if (state_change_c) begin
      t_cnt <= '0;
    end else if (((state == PRESSED) || (state == WAIT_GAP)) && (t_cnt != '1)) begin
      t_cnt <= t_cnt + T_CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!key_flag) state_nxt = PRESSED;
      end
      PRESSED: begin
        // long hold takes priority over a coincident release
        if (t_cnt == LONG_MAX) begin
          state_nxt = LONG_HELD;
          long_nxt  = 1'b1;
        end else if (rel_confirm_c) begin
          state_nxt = WAIT_GAP;
        end
      end
      LONG_HELD: begin
        if (rel_confirm_c) state_nxt = IDLE;
      end
      WAIT_GAP: begin
        // a second press on the last gap cycle still counts as double
        if (!key_flag) begin
          state_nxt  = SECOND_PRESS;
          double_nxt = 1'b1;
        end else if (t_cnt == GAP_MAX) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end
      end
      SECOND_PRESS: begin
        if (rel_confirm_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed and random gestures checked against a
// gesture-level timing model built from release runs, hold and gap windows.
module tb_key_event_decoder;
  import taxi_key_pkg::*;

  localparam int REL  = 4;
  localparam int LONG = 50;
  localparam int GAP  = 20;
  localparam int LEN  = 256;
  localparam int EV_SHORT  = 1;
  localparam int EV_LONG   = 2;
  localparam int EV_DOUBLE = 3;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic key_in;
  logic key_flag;
  logic short_press;
  logic long_press;
  logic double_press;
  logic key_busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic key_a  [LEN];
  logic flag_a [LEN];

  int r_h, r_nb, r_d, r_h2;
  bit r_dbl, r_spur;

  key_event_decoder #(
    .REL_MAX  (20'd4),
    .LONG_MAX (26'd50),
    .GAP_MAX  (26'd20)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .key_in       (key_in),
    .key_flag     (key_flag),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press),
    .key_busy     (key_busy)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [3:0] obs_now();
    return {short_press, long_press, double_press, key_busy};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed {short,long,double,busy}=%b expected %b", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, sample at the falling edge, advance past the rising edge
  task automatic cyc(input logic kin, input logic kflag, input logic [3:0] exp, input string tag);
    key_in   = kin;
    key_flag = kflag;
    @(negedge sys_clk);
    check(tag, obs_now(), exp);
    @(posedge sys_clk);
    #1;
  endtask

  // First cycle >= entry that ends a run of REL+1 high key cycles inside the state
  function automatic int first_confirm(input int entry);
    int run;
    run = 0;
    for (int n = entry; n < LEN; n++) begin
      if (key_a[n]) begin
        run++;
        if (run >= REL + 1) return n;
      end else begin
        run = 0;
      end
    end
    return LEN;
  endfunction

  // Cycle 0 is the key_flag low cycle; everything else is timed from it
  task automatic run_gesture(input int h, input int nb, input int bhi, input int blo,
                             input bit dbl, input int d, input int h2, input bit spur,
                             input string tag);
    int p, hi, lo, c_rel, ev, ev_t, fin, s, pulses;
    logic [3:0] exp, obs;
    for (int i = 0; i < LEN; i++) begin
      key_a[i]  = 1'b1;
      flag_a[i] = 1'b1;
    end
    flag_a[0] = 1'b0;
    for (int i = 0; i < h; i++) key_a[i] = 1'b0;
    p = h;
    for (int b = 0; b < nb; b++) begin
      hi = (bhi > 0) ? bhi : int'($urandom_range(1, REL));
      lo = (blo > 0) ? blo : int'($urandom_range(1, 3));
      p += hi;
      for (int k = 0; k < lo; k++) key_a[p + k] = 1'b0;
      p += lo;
    end
    if (spur && h >= 3) flag_a[int'($urandom_range(2, h - 1))] = 1'b0;

    c_rel = first_confirm(1);
    if (LONG + 1 <= c_rel) begin
      ev   = EV_LONG;
      ev_t = LONG + 2;
      fin  = first_confirm(ev_t) + 1;
    end else begin
      if (dbl) begin
        s = c_rel + 1 + d;
        flag_a[s] = 1'b0;
        for (int k = 0; k < h2; k++) key_a[s + k] = 1'b0;
      end
      ev   = EV_SHORT;
      ev_t = c_rel + 2 + GAP;
      for (int n = c_rel + 1; n <= c_rel + 1 + GAP; n++) begin
        if (ev == EV_SHORT && !flag_a[n]) begin
          ev   = EV_DOUBLE;
          ev_t = n + 1;
        end
      end
      fin = (ev == EV_DOUBLE) ? first_confirm(ev_t) + 1 : ev_t;
    end

    pulses = 0;
    for (int n = 0; n < fin + 6; n++) begin
      exp = {(ev == EV_SHORT) && (n == ev_t), (ev == EV_LONG) && (n == ev_t),
             (ev == EV_DOUBLE) && (n == ev_t), (n >= 1) && (n < fin)};
      key_in   = key_a[n];
      key_flag = flag_a[n];
      @(negedge sys_clk);
      obs = obs_now();
      check(tag, obs, exp);
      if (obs[3:1] != 3'b000) pulses++;
      @(posedge sys_clk);
      #1;
    end
    n_tests++;
    assert (pulses === 1) else begin
      n_fail++;
      $error("FAIL %s_events: observed %0d event pulses expected 1", tag, pulses);
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    key_in    = 1'b1;
    key_flag  = 1'b1;

    // Held in reset with toggling inputs
    for (int i = 0; i < 6; i++) begin
      key_in   = i[0];
      key_flag = i[1];
      @(negedge sys_clk);
      check("reset", obs_now(), 4'b0000);
      @(posedge sys_clk);
      #1;
    end
    sys_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 4'b0000, "post_reset");

    run_gesture(10, 0, 0, 0, 1'b0, 0, 0, 1'b0, "short");
    run_gesture(80, 0, 0, 0, 1'b0, 0, 0, 1'b0, "long");
    run_gesture(10, 0, 0, 0, 1'b1, 7, 6, 1'b0, "double");
    run_gesture(10, 1, 3, 2, 1'b0, 0, 0, 1'b0, "bounce");
    run_gesture(10, 0, 0, 0, 1'b1, GAP, 4, 1'b0, "gap_edge");
    run_gesture(47, 0, 0, 0, 1'b0, 0, 0, 1'b0, "long_tie");
    run_gesture(12, 0, 0, 0, 1'b0, 0, 0, 1'b1, "spur_flag");

    for (int g = 0; g < 25; g++) begin
      r_h    = int'($urandom_range(1, 75));
      r_nb   = int'($urandom_range(0, 2));
      r_dbl  = bit'($urandom_range(0, 1));
      r_d    = int'($urandom_range(0, GAP));
      r_h2   = int'($urandom_range(1, 15));
      r_spur = ($urandom_range(0, 3) == 0);
      run_gesture(r_h, r_nb, 0, 0, r_dbl, r_d, r_h2, r_spur, "rand");
    end

    // Reset in WAIT_GAP must abort without any event
    cyc(1'b0, 1'b0, 4'b0000, "midrst_press");
    for (int i = 1; i < 10; i++) cyc(1'b0, 1'b1, 4'b0001, "midrst_hold");
    for (int i = 0; i < 11; i++) cyc(1'b1, 1'b1, 4'b0001, "midrst_gap");
    sys_rst_n = 1'b0;
    #2;
    check("midrst_async", obs_now(), 4'b0000);
    @(posedge sys_clk);
    #1;
    cyc(1'b1, 1'b1, 4'b0000, "midrst_in");
    sys_rst_n = 1'b1;
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b1, 4'b0000, "midrst_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
